// File: rtl/ck_meter_pkg.sv
// Shared constants and state encoding for the ck_meter slow-clock period/duty meter.
// Defaults match the standard 100 000 000 divider so meter and divider stay consistent.
package ck_meter_pkg;

  localparam int unsigned CK_DEFAULT_WIDTH = 28;
  localparam logic [CK_DEFAULT_WIDTH-1:0] CK_DEFAULT_TIMEOUT = 28'd200000000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ck_meter_state_t;

endpackage

// File: rtl/ck_meter_sync.sv
// Two-flop synchronizer plus history flop for the measured slow clock;
// produces the synchronized level and single-cycle rise/fall pulses.
module ck_meter_sync (
  input  logic clock_in,
  input  logic reset_n,
  input  logic clock_slow,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= clock_slow;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign level = sync2;
  assign rise  = sync2 & ~hist;
  assign fall  = ~sync2 & hist;

endmodule

// File: rtl/ck_meter.sv
// Period and duty-cycle meter for a slow clock sampled in the clock_in domain.
// Define CK_METER_DUTY_EN to build the high-time measurement; otherwise high_time is 0.
module ck_meter
  import ck_meter_pkg::*;
#(
  parameter int unsigned          WIDTH   = CK_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]     TIMEOUT = WIDTH'(CK_DEFAULT_TIMEOUT)
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             clock_slow,
  input  logic             clear,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  ck_meter_state_t  state;
  logic [WIDTH-1:0] cnt;
  logic             level;
  logic             rise;
  logic             fall;

  ck_meter_sync u_sync (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .clock_slow (clock_slow),
    .level      (level),
    .rise       (rise),
    .fall       (fall)
  );

  // A rise in IDLE only arms the meter; snapshots are published on later rises.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      period   <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      cnt      <= '0;
      period   <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= RUN;
            cnt   <= WIDTH'(1);
          end else begin
            cnt <= '0;
          end
        end
        RUN: begin
          if (rise) begin
            period <= cnt;
            valid  <= 1'b1;
            locked <= 1'b1;
            cnt    <= WIDTH'(1);
          end else if (cnt == TIMEOUT) begin
            overflow <= 1'b1;
            locked   <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
      endcase
    end
  end

`ifdef CK_METER_DUTY_EN
  logic [WIDTH-1:0] hcnt;
  logic [WIDTH-1:0] hpend;

  // hpend holds the high count of the period in progress until the next rise publishes it.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      hcnt      <= '0;
      hpend     <= '0;
      high_time <= '0;
    end else if (clear) begin
      hcnt      <= '0;
      hpend     <= '0;
      high_time <= '0;
    end else begin
      if (rise) begin
        hcnt <= WIDTH'(1);
      end else if (level) begin
        hcnt <= hcnt + WIDTH'(1);
      end
      if (fall && state == RUN) begin
        hpend <= hcnt;
      end
      if (rise && state == RUN) begin
        high_time <= hpend;
      end
    end
  end
`else
  logic duty_unused;
  assign duty_unused = level ^ fall;
  assign high_time   = '0;
`endif

endmodule

// File: tb/tb_ck_meter.sv
// Self-checking bench for ck_meter (TIMEOUT=50); honours CK_METER_DUTY_EN for high_time.
// Expectations come from slow-clock edge timestamps kept by the bench.
module tb_ck_meter;

  localparam int W = 28;

  logic          clock_in;
  logic          reset_n;
  logic          clock_slow;
  logic          clear;
  logic [W-1:0]  period;
  logic [W-1:0]  high_time;
  logic          valid;
  logic          locked;
  logic          overflow;

  ck_meter #(.WIDTH(W), .TIMEOUT(28'd50)) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .clock_slow (clock_slow),
    .clear      (clear),
    .period     (period),
    .high_time  (high_time),
    .valid      (valid),
    .locked     (locked),
    .overflow   (overflow)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc++;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic eq(input string name, input longint act, input longint req);
    chk(name, act == req, act, req);
  endtask

  function automatic int exp_high(input int h);
`ifdef CK_METER_DUTY_EN
    return h;
`else
    return 0;
`endif
  endfunction

  // Reference model: measurement of a period is the distance between two
  // sampled rises, published 3 cycles after the closing rise.
  typedef struct {
    int vcyc;
    int per;
    int hi;
  } exp_t;

  exp_t q[$];
  bit   have_rise = 0;
  bit   have_fall = 0;
  int   last_rise = 0;
  int   last_fall = 0;
  bit   mon_en    = 0;

  function automatic void model_reset();
    q.delete();
    have_rise = 0;
    have_fall = 0;
  endfunction

  function automatic void model_rise(input int t);
    exp_t e;
    if (have_rise && have_fall) begin
      e.vcyc = t + 3;
      e.per  = t - last_rise;
      e.hi   = last_fall - last_rise;
      q.push_back(e);
    end
    have_rise = 1;
    have_fall = 0;
    last_rise = t;
  endfunction

  function automatic void model_fall(input int t);
    if (have_rise) begin
      have_fall = 1;
      last_fall = t;
    end
  endfunction

  always @(negedge clock_in) begin
    exp_t e;
    if (mon_en && valid) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL spurious_valid: actual valid=1 period=%0d required no valid (cycle %0d)", period, cyc);
      end else begin
        e = q.pop_front();
        eq("valid_cycle", cyc, e.vcyc);
        eq("period", period, e.per);
        eq("high_time", high_time, exp_high(e.hi));
        eq("locked_on_valid", locked, 1);
      end
    end
  end

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    if (v && !clock_slow) model_rise(cyc);
    else if (!v && clock_slow) model_fall(cyc);
    clock_slow = v;
    repeat (n) step();
  endtask

  task automatic drained();
    repeat (4) step();
    eq("pending_valids", q.size(), 0);
  endtask

  task automatic outputs_zero(input string tag);
    eq({tag, "_period"}, period, 0);
    eq({tag, "_high_time"}, high_time, 0);
    eq({tag, "_valid"}, valid, 0);
    eq({tag, "_locked"}, locked, 0);
    eq({tag, "_overflow"}, overflow, 0);
  endtask

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_period;
    int exp_hi;
  } row_t;

  row_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    int ocyc;
    int exp_ocyc;
    int nval;

    tbl[0] = '{hi: 5,  lo: 5,  n: 4, exp_period: 10, exp_hi: 5};
    tbl[1] = '{hi: 3,  lo: 7,  n: 4, exp_period: 10, exp_hi: 3};
    tbl[2] = '{hi: 2,  lo: 2,  n: 4, exp_period: 4,  exp_hi: 2};
    tbl[3] = '{hi: 20, lo: 20, n: 3, exp_period: 40, exp_hi: 20};
    tbl[4] = '{hi: 7,  lo: 13, n: 3, exp_period: 20, exp_hi: 7};
    tbl[5] = '{hi: 2,  lo: 30, n: 3, exp_period: 32, exp_hi: 2};

    clock_slow = 1'b0;
    clear      = 1'b0;
    reset_n    = 1'b0;
    repeat (3) @(posedge clock_in);
    #1;
    outputs_zero("reset");
    reset_n = 1'b1;
    step();
    mon_en = 1;

    // Steady waveforms from the table
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < tbl[r].n; p++) begin
        drive(1'b1, tbl[r].hi);
        drive(1'b0, tbl[r].lo);
      end
      eq("row_period", period, tbl[r].exp_period);
      eq("row_high_time", high_time, exp_high(tbl[r].exp_hi));
      eq("row_locked", locked, 1);
      eq("row_overflow", overflow, 0);
    end
    drained();

    // Random phases, each at least 2 cycles
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, int'($urandom_range(20, 2)));
      drive(1'b0, int'($urandom_range(20, 2)));
    end
    drained();

    // Timeout: period 20 then held low
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 10);
      drive(1'b0, 10);
    end
    exp_ocyc = last_rise + 53;
    ocyc = -1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clock_in);
      if (overflow) begin
        ocyc = cyc;
        break;
      end
    end
    eq("overflow_set", overflow, 1);
    eq("overflow_cycle", ocyc, exp_ocyc);
    eq("timeout_locked", locked, 0);
    eq("timeout_period_kept", period, 20);
    eq("timeout_high_kept", high_time, exp_high(10));
    step();
    drained();
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 10);
      drive(1'b0, 10);
    end
    drained();
    eq("overflow_sticky", overflow, 1);
    eq("relock", locked, 1);
    eq("restart_period", period, 20);

    // Clear coinciding with a synchronized rise
    drive(1'b1, 3);
    drive(1'b0, 5);
    clock_slow = 1'b1;
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clock_in);
    outputs_zero("clear");
    model_reset();
    step();
    drive(1'b1, 1);
    drive(1'b0, 5);
    drive(1'b1, 5);
    drive(1'b0, 5);
    drive(1'b1, 4);
    drive(1'b0, 6);
    drained();
    eq("post_clear_period", period, 10);
    eq("post_clear_high", high_time, exp_high(4));

    // Asynchronous reset pulse mid-period
    drive(1'b1, 5);
    drive(1'b0, 2);
    #2;
    reset_n = 1'b0;
    #1;
    outputs_zero("async_reset");
    #9;
    reset_n = 1'b1;
    @(posedge clock_in);
    #1;
    model_reset();
    drive(1'b0, 1);
    drive(1'b1, 5);
    drive(1'b0, 5);
    drive(1'b1, 5);
    drive(1'b0, 5);
    drained();
    eq("post_reset_locked", locked, 1);
    eq("post_reset_period", period, 10);

    // Asynchronous slow clock, 25.1 cycles nominal 25
    clear = 1'b1;
    step();
    clear = 1'b0;
    mon_en = 0;
    nval = 0;
    fork
      begin
        #2;
        repeat (24) begin
          clock_slow = 1'b1;
          #125;
          clock_slow = 1'b0;
          #126;
        end
      end
      begin
        repeat (620) begin
          @(negedge clock_in);
          if (valid) begin
            nval++;
            chk("async_period", period >= 24 && period <= 26, period, 25);
          end
        end
      end
    join
    eq("async_valid_count", nval, 23);
    eq("async_overflow", overflow, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ck_meter.md
# ck_meter

Period and duty-cycle meter for a slow clock such as the divided `clock_200`-style outputs used across the counter designs. It samples an asynchronous slow clock in the `clock_in` domain and measures its period and high time in `clock_in` cycles. It then publishes both values as one coherent snapshot per slow-clock period. It is the measuring end of the divider: a divider turns a count into a clock, and this block recovers the count from the clock, for self-check and display.

## Interface
Parameters:
- `WIDTH`, 28: width of all cycle counts.
- `TIMEOUT`, 28'd200000000: maximum cycles allowed between rising edges before overflow (2× the standard 100 000 000 divisor).

Ports:
- `clock_in`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clock_slow`  in  1  measured clock; asynchronous to `clock_in`.
- `clear`  in  1  synchronous restart of measurement.
- `period`  out  WIDTH  last measured period in `clock_in` cycles.
- `high_time`  out  WIDTH  high cycles within that period.
- `valid`  out  1  one-cycle strobe when `period`/`high_time` update.
- `locked`  out  1  at least one full period has been measured since the last reset, clear or timeout.
- `overflow`  out  1  sticky timeout flag.

## Operation
- Input stage: two-flop synchronizer, plus a history flop.
  - `rise` = sync2 & ~hist.
  - `fall` = ~sync2 & hist.
- States:
  - IDLE: `cnt`=0. Go to RUN on `rise`, setting `cnt`=1.
  - RUN: `cnt` increments each cycle.
    - On `rise`: `period`<=`cnt`, `high_time`<=`hpend`, `valid`=1, `locked`=1, `cnt`<=1.
    - On `fall`: `hpend`<=`hcnt`.
    - `cnt`==`TIMEOUT` with no `rise`: `overflow`<=1, `locked`<=0, go to IDLE. `period` and `high_time` keep their last values.
- High counter: `hcnt`<=1 on `rise`, then increments while sync2 is high.
- Arithmetic: unsigned, WIDTH bits. `TIMEOUT` must be < 2^WIDTH, so `cnt` never wraps.
- The first `rise` after IDLE only arms the meter and produces no `valid`.
- `clear` has priority over `rise`/`fall`/timeout in the same cycle.
  - It forces IDLE and zeroes `period`, `high_time`, `valid`, `locked`, `overflow`, `cnt`, `hcnt` and `hpend`.
  - The `rise` occurring in that same cycle is discarded.
- Reset: every output is 0, the synchronizer and history flops are 0, and the state is IDLE.
- Reset asserted mid-measurement: state is lost immediately. The block re-arms on the first `rise` after release.

## Timing
- Latency from a `clock_slow` rising transition (first sampled at `clock_in` edge n) to `valid`=1: 3 cycles (edge n+2 registers outputs).
- Rising and falling edges have identical latency, so measurements are exact for slow clocks synchronous to `clock_in`.
- For asynchronous slow clocks, measurements are within ±1 cycle.
- `valid` is high exactly 1 cycle per measured period. `period` and `high_time` change only in that cycle, or on `clear`.
- Minimum measurable input: each phase ≥2 `clock_in` cycles (period ≥4). Shorter pulses may be missed, with no other requirement.

## Configuration
- `CK_METER_DUTY_EN`
  - Defined: `hcnt`, `hpend` and `high_time` are implemented as above.
  - Undefined: no high-time logic is built. `high_time` is tied to 0, and `period`, `valid`, `locked` and `overflow` behave identically.

## Structure
- `ck_meter_pkg` holds:
  - The state encoding (IDLE=1'b0, RUN=1'b1).
  - Default `WIDTH` and `TIMEOUT` constants, shared with the divider so the defaults stay consistent.
- Sub-module `ck_meter_sync`: two-flop synchronizer, history flop, and the `rise`/`fall` pulses, with `clock_in`/`reset_n`.
- The top level holds the FSM, counters and output registers.

## Test plan
- Run `clock_slow` with period 10 (5 high, 5 low), synchronous to `clock_in`.
  - First `valid` appears at the second rising edge + 3 cycles.
  - Then `period`=10 and `high_time`=5, with `valid` once every 10 cycles.
  - `locked`=1 from the first `valid`.
- Duty 3/10, macro defined: `period`=10, `high_time`=3. Same run with the macro undefined: `high_time`=0 and `period`=10.
- `TIMEOUT`=50, slow clock with period 20, then held low.
  - `overflow`=1 and `locked`=0 exactly 50 cycles after the last counted rise; `period` stays 20.
  - After the clock restarts, the first `valid` comes at the second rise, and `overflow` remains 1.
- Assert `clear` in the same cycle as a `rise` mid-run.
  - All outputs go to 0 next cycle.
  - The next `rise` arms only; `valid` comes one period later with the correct value.
- Pulse `reset_n` low for 1 cycle mid-period, asynchronously.
  - All outputs are 0 immediately.
  - After release, there is no `valid` until two rises have been seen.
- Asynchronous slow clock, period 100000000 nominal, against a 100 MHz `clock_in` (shortened with `TIMEOUT` scaled for simulation).
  - Every reported `period` is within ±1 of nominal, and `overflow` stays 0.
